// File: rtl/vga_sram_arbiter_if.sv
// vga_sram_arbiter_if: bundles the VGA, CPU and SRAM sides of the arbiter
// Ports (slave = arbiter view):
//   VGA : vga_req, vga_addr[31:0], vga_byte_sel[3:0] in; vga_rdata[31:0], vga_busy, vga_done out
//   CPU : cpu_req, cpu_wen, cpu_addr[31:0], cpu_wdata[31:0], cpu_byte_sel[3:0] in;
//         cpu_rdata[31:0], cpu_busy, cpu_done out
//   SRAM: sram_rdata[31:0], sram_ack in; sram_req, sram_wen, sram_addr[31:0],
//         sram_wdata[31:0], sram_byte_sel[3:0] out
//   Status: timeout_err out
// The master modport is the mirror image, used by whatever drives requests and models the SRAM.
interface vga_sram_arbiter_if;
    logic        vga_req;
    logic [31:0] vga_addr;
    logic [3:0]  vga_byte_sel;
    logic [31:0] vga_rdata;
    logic        vga_busy;
    logic        vga_done;
    logic        cpu_req;
    logic        cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byte_sel;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic        sram_req;
    logic        sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_byte_sel;
    logic [31:0] sram_rdata;
    logic        sram_ack;
    logic        timeout_err;

    modport slave (
        input  vga_req, vga_addr, vga_byte_sel,
        input  cpu_req, cpu_wen, cpu_addr, cpu_wdata, cpu_byte_sel,
        input  sram_rdata, sram_ack,
        output vga_rdata, vga_busy, vga_done,
        output cpu_rdata, cpu_busy, cpu_done,
        output sram_req, sram_wen, sram_addr, sram_wdata, sram_byte_sel,
        output timeout_err
    );

    modport master (
        output vga_req, vga_addr, vga_byte_sel,
        output cpu_req, cpu_wen, cpu_addr, cpu_wdata, cpu_byte_sel,
        output sram_rdata, sram_ack,
        input  vga_rdata, vga_busy, vga_done,
        input  cpu_rdata, cpu_busy, cpu_done,
        input  sram_req, sram_wen, sram_addr, sram_wdata, sram_byte_sel,
        input  timeout_err
    );
endinterface

// File: rtl/vga_sram_arbiter.sv
// vga_sram_arbiter: shares one SRAM port between a VGA reader and a CPU reader/writer
// Ports:
//   clk  - single clock, rising edge
//   nrst - asynchronous active-low reset; aborts any transfer and zeroes all outputs
//   bus  - vga_sram_arbiter_if.slave carrying the VGA, CPU and SRAM signal groups
// Parameter:
//   TIMEOUT_CYCLES - XFER cycles without sram_ack before a transfer is aborted (1..255)
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate via a last-grant
//                        flag; otherwise VGA has strict priority.
module vga_sram_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic               clk,
    input logic               nrst,
    vga_sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, VGA_XFER, CPU_XFER} state_t;

    // The watchdog holds k-1 during XFER cycle k, so the abort fires at the end of
    // cycle TIMEOUT_CYCLES.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  wd_q, wd_d;
    logic [31:0] vga_rdata_q, vga_rdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        vga_done_q, vga_done_d;
    logic        cpu_done_q, cpu_done_d;
    logic        sram_wen_q, sram_wen_d;
    logic [31:0] sram_addr_q, sram_addr_d;
    logic [31:0] sram_wdata_q, sram_wdata_d;
    logic [3:0]  sram_byte_sel_q, sram_byte_sel_d;
    logic        timeout_err_q, timeout_err_d;
    logic        pick_vga;
    logic        xfer;
    logic        timeout;
    logic        finish;
    logic [31:0] ret_data;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = VGA was granted last; reset value CPU hands the first tie to VGA
    logic last_vga_q;

    assign pick_vga = bus.vga_req && !(bus.cpu_req && last_vga_q);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            last_vga_q <= 1'b0;
        else if (state_q == IDLE && (bus.vga_req || bus.cpu_req))
            last_vga_q <= pick_vga;
    end
`else
    assign pick_vga = bus.vga_req;
`endif

    assign xfer     = state_q != IDLE;
    // Timeout only counts when no ack arrives, so an ack in the final cycle wins.
    assign timeout  = xfer && !bus.sram_ack && wd_q == WD_LAST;
    assign finish   = xfer && (bus.sram_ack || timeout);
    assign ret_data = bus.sram_ack ? bus.sram_rdata : 32'h0;

    always_comb begin
        state_d         = state_q;
        wd_d            = xfer ? wd_q + 8'd1 : 8'd0;
        vga_rdata_d     = vga_rdata_q;
        cpu_rdata_d     = cpu_rdata_q;
        vga_done_d      = 1'b0;
        cpu_done_d      = 1'b0;
        sram_wen_d      = sram_wen_q;
        sram_addr_d     = sram_addr_q;
        sram_wdata_d    = sram_wdata_q;
        sram_byte_sel_d = sram_byte_sel_q;
        timeout_err_d   = timeout_err_q | timeout;
        if (state_q == IDLE) begin
            if (pick_vga) begin
                state_d         = VGA_XFER;
                sram_wen_d      = 1'b0;
                sram_addr_d     = bus.vga_addr;
                sram_byte_sel_d = bus.vga_byte_sel;
            end else if (bus.cpu_req) begin
                state_d         = CPU_XFER;
                sram_wen_d      = bus.cpu_wen;
                sram_addr_d     = bus.cpu_addr;
                sram_wdata_d    = bus.cpu_wdata;
                sram_byte_sel_d = bus.cpu_byte_sel;
            end
        end else if (finish) begin
            state_d    = IDLE;
            vga_done_d = state_q == VGA_XFER;
            cpu_done_d = state_q == CPU_XFER;
            if (state_q == VGA_XFER)
                vga_rdata_d = ret_data;
            if (state_q == CPU_XFER && !sram_wen_q)
                cpu_rdata_d = ret_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q         <= IDLE;
            wd_q            <= 8'd0;
            vga_rdata_q     <= 32'h0;
            cpu_rdata_q     <= 32'h0;
            vga_done_q      <= 1'b0;
            cpu_done_q      <= 1'b0;
            sram_wen_q      <= 1'b0;
            sram_addr_q     <= 32'h0;
            sram_wdata_q    <= 32'h0;
            sram_byte_sel_q <= 4'h0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            wd_q            <= wd_d;
            vga_rdata_q     <= vga_rdata_d;
            cpu_rdata_q     <= cpu_rdata_d;
            vga_done_q      <= vga_done_d;
            cpu_done_q      <= cpu_done_d;
            sram_wen_q      <= sram_wen_d;
            sram_addr_q     <= sram_addr_d;
            sram_wdata_q    <= sram_wdata_d;
            sram_byte_sel_q <= sram_byte_sel_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign bus.vga_rdata     = vga_rdata_q;
    assign bus.vga_busy      = xfer;
    assign bus.vga_done      = vga_done_q;
    assign bus.cpu_rdata     = cpu_rdata_q;
    assign bus.cpu_busy      = xfer;
    assign bus.cpu_done      = cpu_done_q;
    assign bus.sram_req      = xfer;
    assign bus.sram_wen      = sram_wen_q;
    assign bus.sram_addr     = sram_addr_q;
    assign bus.sram_wdata    = sram_wdata_q;
    assign bus.sram_byte_sel = sram_byte_sel_q;
    assign bus.timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_vga_sram_arbiter.sv
// tb_vga_sram_arbiter: randomized scoreboard bench for vga_sram_arbiter
module tb_vga_sram_arbiter;
    localparam int TO = 15;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // lat = XFER cycle in which the SRAM acks; 0 = never ack (watchdog abort)
    typedef struct {
        bit          is_vga;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  bsel;
        int          lat;
    } tx_t;

    typedef struct {
        bit          is_vga;
        logic [31:0] rdata;
        bit          terr;
    } done_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    vga_sram_arbiter_if bus();
    vga_sram_arbiter #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    tx_t   vga_txq[$];
    tx_t   cpu_txq[$];
    tx_t   grant_q[$];
    done_t done_q[$];
    int    checks = 0;
    int    errors = 0;
    logic [31:0] m_vrd, m_crd;
    bit    m_terr, m_last_vga;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic tx_t mk(bit v, bit w, logic [31:0] a, logic [31:0] d, logic [31:0] r,
                               logic [3:0] b, int l);
        tx_t t;
        t.is_vga = v; t.wen = w; t.addr = a; t.wdata = d; t.rdata = r; t.bsel = b; t.lat = l;
        return t;
    endfunction

    function automatic void model_reset();
        m_vrd = 32'h0; m_crd = 32'h0; m_terr = 1'b0; m_last_vga = 1'b0;
    endfunction

    // Order of service for everything currently queued by both clients, and the
    // completion each transfer must produce.
    function automatic void plan();
        int iv = 0;
        int ic = 0;
        bit pv;
        tx_t t;
        done_t d;
        logic [31:0] rd;
        while (iv < vga_txq.size() || ic < cpu_txq.size()) begin
            if (iv < vga_txq.size() && ic < cpu_txq.size()) pv = RR ? !m_last_vga : 1'b1;
            else pv = iv < vga_txq.size();
            if (pv) begin t = vga_txq[iv]; iv++; end
            else begin t = cpu_txq[ic]; ic++; end
            m_last_vga = pv;
            grant_q.push_back(t);
            rd = (t.lat == 0) ? 32'h0 : t.rdata;
            if (t.lat == 0) m_terr = 1'b1;
            if (pv) m_vrd = rd;
            else if (!t.wen) m_crd = rd;
            d.is_vga = pv;
            d.rdata = pv ? m_vrd : m_crd;
            d.terr = m_terr;
            done_q.push_back(d);
        end
    endfunction

    function automatic int rand_lat();
        int r = $urandom_range(0, 11);
        return (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 4);
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {25'b0, bus.sram_req, bus.sram_wen, bus.vga_busy, bus.cpu_busy,
                            bus.vga_done, bus.cpu_done, bus.timeout_err}, 32'h0);
        chk({tag, "_vga_rdata"}, bus.vga_rdata, 32'h0);
        chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 32'h0);
        chk({tag, "_sram_addr"}, bus.sram_addr, 32'h0);
        chk({tag, "_sram_wdata"}, bus.sram_wdata, 32'h0);
        chk({tag, "_sram_bsel"}, 32'(bus.sram_byte_sel), 32'h0);
    endtask

    task automatic flush();
        vga_txq.delete(); cpu_txq.delete(); grant_q.delete(); done_q.delete();
    endtask

    task automatic drain();
        int n = 0;
        while ((vga_txq.size() + cpu_txq.size() + done_q.size()) != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        checks++;
        if (n >= 3000 || grant_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d done and %0d grants still outstanding after %0d cycles",
                     done_q.size(), grant_q.size(), n);
            flush();
        end
    endtask

    // VGA client: requests while it has work, moves to the next item on vga_done
    initial begin
        bus.vga_req = 1'b0; bus.vga_addr = 32'h0; bus.vga_byte_sel = 4'h0;
        forever begin
            @(posedge clk); #1;
            if (nrst && bus.vga_done && vga_txq.size() > 0) void'(vga_txq.pop_front());
            bus.vga_req = nrst && vga_txq.size() > 0;
            if (vga_txq.size() > 0) begin
                bus.vga_addr = vga_txq[0].addr;
                bus.vga_byte_sel = vga_txq[0].bsel;
            end
        end
    end

    // CPU client
    initial begin
        bus.cpu_req = 1'b0; bus.cpu_wen = 1'b0; bus.cpu_addr = 32'h0;
        bus.cpu_wdata = 32'h0; bus.cpu_byte_sel = 4'h0;
        forever begin
            @(posedge clk); #1;
            if (nrst && bus.cpu_done && cpu_txq.size() > 0) void'(cpu_txq.pop_front());
            bus.cpu_req = nrst && cpu_txq.size() > 0;
            if (cpu_txq.size() > 0) begin
                bus.cpu_wen = cpu_txq[0].wen;
                bus.cpu_addr = cpu_txq[0].addr;
                bus.cpu_wdata = cpu_txq[0].wdata;
                bus.cpu_byte_sel = cpu_txq[0].bsel;
            end
        end
    end

    // SRAM model: checks each command against the expected grant order, holds the
    // strobe length, and sprinkles stray acks while idle
    initial begin
        tx_t cur;
        int  cnt = 0;
        bit  active = 1'b0;
        bit  ended;
        bus.sram_ack = 1'b0; bus.sram_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            ended = 1'b0;
            if (!nrst) begin
                active = 1'b0;
                bus.sram_ack = 1'b0;
            end else begin
                if (active) begin
                    if (cnt == ((cur.lat == 0) ? TO : cur.lat)) begin
                        chk("xfer_end", {29'b0, bus.sram_req, bus.vga_busy, bus.cpu_busy}, 32'h0);
                        active = 1'b0;
                        ended = 1'b1;
                    end else begin
                        cnt++;
                        chk("xfer_hold", {29'b0, bus.sram_req, bus.vga_busy, bus.cpu_busy}, 32'h7);
                    end
                end
                if (!active && !ended && bus.sram_req) begin
                    if (grant_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant: sram_req=1 addr %h, expected no grant",
                                 bus.sram_addr);
                    end else begin
                        cur = grant_q.pop_front();
                        active = 1'b1;
                        cnt = 1;
                        chk("grant_addr", bus.sram_addr, cur.addr);
                        chk("grant_bsel", 32'(bus.sram_byte_sel), 32'(cur.bsel));
                        chk("grant_wen", 32'(bus.sram_wen), 32'(cur.wen));
                        if (cur.wen) chk("grant_wdata", bus.sram_wdata, cur.wdata);
                        chk("grant_busy", {30'b0, bus.vga_busy, bus.cpu_busy}, 32'h3);
                    end
                end
                bus.sram_ack = active ? (cnt == cur.lat) : 1'($urandom_range(0, 1));
                bus.sram_rdata = active ? cur.rdata : $urandom;
            end
        end
    end

    task automatic take(input bit v);
        done_t d;
        if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: %s done pulsed, expected none", v ? "vga" : "cpu");
        end else begin
            d = done_q.pop_front();
            chk("done_owner", 32'(v), 32'(d.is_vga));
            chk(v ? "vga_rdata" : "cpu_rdata", v ? bus.vga_rdata : bus.cpu_rdata, d.rdata);
            chk("timeout_err", 32'(bus.timeout_err), 32'(d.terr));
        end
    endtask

    // Completion monitor
    initial begin
        forever begin
            @(posedge clk); #1;
            if (nrst) begin
                if (bus.vga_done) take(1'b1);
                if (bus.cpu_done) take(1'b0);
            end
        end
    end

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_zero("in_reset");
        @(negedge clk) nrst = 1'b1;
        @(posedge clk); #1 check_zero("post_reset");

        // lone VGA read, ack in third XFER cycle
        @(negedge clk);
        vga_txq.push_back(mk(1, 0, 32'd5, 32'h0, 32'hFFFF_FFFF, 4'hF, 3));
        plan(); drain();
        chk("vga_read_ff", bus.vga_rdata, 32'hFFFF_FFFF);

        // CPU read then write; the write must leave cpu_rdata alone
        @(negedge clk);
        cpu_txq.push_back(mk(0, 0, 32'd7, 32'h0, 32'hCAFE_F00D, 4'hF, 2));
        cpu_txq.push_back(mk(0, 1, 32'd9, 32'h1234_ABCD, 32'h5555_AAAA, 4'b0011, 2));
        plan(); drain();
        chk("cpu_write_keeps_rdata", bus.cpu_rdata, 32'hCAFE_F00D);

        // simultaneous requests, three of each, both held
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vga_txq.push_back(mk(1, 0, 32'h100 + i, 32'h0, $urandom, 4'hF, 2));
            cpu_txq.push_back(mk(0, 0, 32'h200 + i, 32'h0, $urandom, 4'h3, 2));
        end
        plan(); drain();

        // ack in the same cycle the watchdog expires: ack wins
        @(negedge clk);
        cpu_txq.push_back(mk(0, 0, 32'h33, 32'h0, 32'h0BAD_BEEF, 4'h1, TO));
        plan(); drain();
        chk("tie_no_timeout", 32'(bus.timeout_err), 32'h0);

        // no ack at all: abort, zero data, sticky error
        @(negedge clk);
        vga_txq.push_back(mk(1, 0, 32'h44, 32'h0, 32'h1111_2222, 4'hC, 0));
        plan(); drain();
        chk("timeout_rdata", bus.vga_rdata, 32'h0);
        chk("timeout_set", 32'(bus.timeout_err), 32'h1);
        @(negedge clk);
        cpu_txq.push_back(mk(0, 0, 32'h55, 32'h0, 32'h7777_8888, 4'hF, 1));
        plan(); drain();
        chk("timeout_sticky", 32'(bus.timeout_err), 32'h1);

        // randomized mixed traffic
        for (int b = 0; b < 40; b++) begin
            int nv = $urandom_range(0, 3);
            int nc = $urandom_range(0, 3);
            @(negedge clk);
            for (int i = 0; i < nv; i++)
                vga_txq.push_back(mk(1, 0, $urandom, 32'h0, $urandom, 4'($urandom), rand_lat()));
            for (int i = 0; i < nc; i++)
                cpu_txq.push_back(mk(0, 1'($urandom), $urandom, $urandom, $urandom,
                                     4'($urandom), rand_lat()));
            plan(); drain();
        end

        // reset in the middle of a CPU transfer
        @(negedge clk);
        cpu_txq.push_back(mk(0, 0, 32'h66, 32'h0, 32'hA5A5_0001, 4'hF, 1));
        plan(); drain();
        @(negedge clk);
        cpu_txq.push_back(mk(0, 1, 32'h77, 32'hDEAD_0001, 32'h0, 4'hF, 0));
        plan();
        n = 0;
        while (!bus.sram_req && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL reset_setup: sram_req never rose, expected a CPU grant");
        end
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        #1 check_zero("async_reset");
        flush();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) nrst = 1'b1;
        repeat (10) @(posedge clk);
        #1 check_zero("after_reset_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_sram_arbiter.md
VGA_SRAM_ARBITER -- requirements
Module: vga_sram_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 15, cycles without sram_ack before a transfer is aborted (legal 1..255).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 nrst  in  1  reset, asynchronous, active-low.
REQ-004 vga_req  in  1  VGA read request (VGA data_en); held high until vga_done.
REQ-005 vga_addr / vga_byte_sel  in  32 / 4  VGA word address and byte select.
REQ-006 vga_rdata  out  32  registered read data returned to VGA.
REQ-007 vga_busy / vga_done  out  1 / 1  arbiter-busy indication to VGA (its SRAM_busy); one-cycle completion pulse.
REQ-008 cpu_req / cpu_wen  in  1 / 1  CPU request; 1 = write, 0 = read; held until cpu_done.
REQ-009 cpu_addr / cpu_wdata / cpu_byte_sel  in  32 / 32 / 4  CPU address, write data, byte select.
REQ-010 cpu_rdata  out  32  registered CPU read data.
REQ-011 cpu_busy / cpu_done  out  1 / 1  arbiter-busy indication; one-cycle completion pulse.
REQ-012 sram_req / sram_wen  out  1 / 1  SRAM access strobe; write enable.
REQ-013 sram_addr / sram_wdata / sram_byte_sel  out  32 / 32 / 4  registered SRAM command fields.
REQ-014 sram_rdata / sram_ack  in  32 / 1  SRAM read data; completion, valid for one cycle.
REQ-015 timeout_err  out  1  sticky flag: a transfer was aborted by timeout.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, VGA_XFER, CPU_XFER.
REQ-017 In IDLE with a pending request, the FSM SHALL grant on the next edge and latch the winner's addr/byte_sel (plus wen/wdata for CPU) into the sram_* registers.
REQ-018 sram_req SHALL be 1 in every VGA_XFER/CPU_XFER cycle and 0 in IDLE; sram_wen is 0 for all VGA transfers.
REQ-019 A sram_ack seen in an XFER state SHALL return the FSM to IDLE, load sram_rdata into the owner's rdata register (reads only), and pulse the owner's done for exactly the following cycle.
REQ-020 A CPU write SHALL leave cpu_rdata unchanged.
REQ-021 vga_busy SHALL be 1 whenever the FSM is not IDLE; cpu_busy SHALL follow the same rule.
REQ-022 Minimum grant spacing: the earliest new grant SHALL be one cycle after the ack cycle (one IDLE cycle between transfers).
REQ-023 An 8-bit watchdog SHALL clear on grant and increment each XFER cycle without ack; on reaching TIMEOUT_CYCLES, the FSM SHALL return to IDLE, load the owner's rdata with 32'h0 (reads), pulse done, and set timeout_err.
REQ-024 If ack and timeout occur in the same cycle, ack SHALL win and timeout_err SHALL NOT be set.
REQ-025 If a request is deasserted mid-transfer, the transfer SHALL still complete and done SHALL still pulse.
REQ-026 sram_ack received in IDLE SHALL be ignored.

Reset
REQ-027 nrst low SHALL immediately force IDLE, clear the watchdog, and zero all outputs (including rdata registers and timeout_err), aborting any in-flight transfer without a done pulse.
REQ-028 timeout_err SHALL be cleared only by reset.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN undefined: when both requests are pending in IDLE, VGA SHALL always win (strict priority).
REQ-030 ARB_ROUND_ROBIN_EN defined: a last-grant flag (reset = CPU) SHALL give a simultaneous request to the requester not granted last; a lone request is granted immediately in both builds.

Verification
REQ-031 Lone VGA read at addr 5, ack after 3 XFER cycles with rdata 32'hFFFFFFFF -> sram_req high for 3 cycles, vga_rdata = FFFFFFFF, vga_done pulses once.
REQ-032 CPU write addr 9, wdata 32'h1234ABCD, byte_sel 4'b0011 -> sram_wen = 1, fields match, cpu_rdata unchanged, cpu_done pulses.
REQ-033 vga_req and cpu_req rise together, repeated 3 times -> without macro: grants V,V,V with CPU starved while VGA is held; with macro: grants V,C,V.
REQ-034 Never ack, TIMEOUT_CYCLES = 15 -> abort after 15 XFER cycles, rdata = 0, done pulses, timeout_err = 1 and holds.
REQ-035 Assert nrst low during CPU_XFER -> all outputs 0 in the same cycle, no cpu_done, FSM in IDLE after release.
